// File: rtl/id_hazard_stall_unit_pkg.sv
// ---------------------------------------------------------------------------
// id_hazard_stall_unit_pkg
//   Shared types and constants for the ID-stage hazard/stall unit.
//   - REG_IDX_W       : width of a register index
//   - WB_CTRL_WEN_BIT : position of the register-write enable in WB_CTRL
//   - sb_entry_t      : one scoreboard slot {valid, destination register}
//   - stall_state_e   : stall FSM state encoding
//   - slot_hit()      : does a scoreboard slot produce the given source?
// ---------------------------------------------------------------------------
package id_hazard_stall_unit_pkg;

    localparam int REG_IDX_W       = 3;
    localparam int WB_CTRL_WEN_BIT = 0;

    typedef struct packed {
        logic                 v;
        logic [REG_IDX_W-1:0] r;
    } sb_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_e;

    // Register 0 is hardwired to zero on some cores, so it can never be a
    // true producer when r0_zero is set.
    function automatic logic slot_hit(input sb_entry_t            e,
                                      input logic [REG_IDX_W-1:0] rs,
                                      input bit                   r0_zero);
        return e.v && (e.r == rs) && !(r0_zero && (rs == '0));
    endfunction

endpackage

// File: rtl/id_hazard_stall_unit_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Three-slot shift register mirroring the destination registers held in
//   ID/EX, EX/MEM and MEM/WB, plus the source-operand compare against it.
//   Ports:
//     clk, reset          : clock, synchronous active-low reset
//     push                : entry entering ID/EX at the next edge
//     rs1, rs2            : ID-stage source register indices
//     use_rs1, use_rs2    : ID instruction actually reads rs1 / rs2
//     match_rs1, match_rs2: a valid in-flight producer writes rs1 / rs2
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import id_hazard_stall_unit_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b0,
    parameter bit R0_ZERO   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  sb_entry_t            push,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic                 use_rs1,
    input  logic                 use_rs2,
    output logic                 match_rs1,
    output logic                 match_rs2
);

    sb_entry_t sb_ex, sb_mem, sb_wb;

    // NOTE: the slots are reset (not left X) because their valid bits feed
    // the stall decision directly; non-blocking assignments let each slot
    // take the previous value of its neighbour, giving a true shift.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            sb_ex  <= push;
        end
    end

    // The ID instruction itself only enters sb_ex at the next edge, so its
    // own destination is never compared against its own sources.
    function automatic logic any_hit(input logic [REG_IDX_W-1:0] rs);
        return slot_hit(sb_ex, rs, R0_ZERO)
             | slot_hit(sb_mem, rs, R0_ZERO)
             | (!WB_BYPASS && slot_hit(sb_wb, rs, R0_ZERO));
    endfunction

    assign match_rs1 = use_rs1 && any_hit(rs1);
    assign match_rs2 = use_rs2 && any_hit(rs2);

endmodule

// File: rtl/id_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// id_hazard_stall_unit
//   Read-after-write interlock for a pipeline without forwarding. Stalls PC
//   and IF/ID and bubbles ID/EX while an in-flight producer owns one of the
//   ID sources; a taken branch (EX_flush) squashes ID and wins over a stall.
//   Ports:
//     clk, reset             : clock, synchronous active-low reset
//     ID_valid               : real instruction in ID
//     ID_rs1, ID_rs2         : source register indices
//     ID_use_rs1, ID_use_rs2 : instruction reads rs1 / rs2
//     ID_Wreg, ID_wen        : destination register / write enable
//     EX_flush               : taken branch resolved in EX
//     stall                  : hold PC and IF/ID
//     id_ex_bubble           : zero the ID/EX control fields
//     stall_cnt              : saturating count of stall cycles
//     hazard_err             : sticky, a stall run exceeded MAX_STALL
// ---------------------------------------------------------------------------
module id_hazard_stall_unit
    import id_hazard_stall_unit_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b0,
    parameter bit R0_ZERO   = 1'b0,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ID_valid,
    input  logic [REG_IDX_W-1:0] ID_rs1,
    input  logic [REG_IDX_W-1:0] ID_rs2,
    input  logic                 ID_use_rs1,
    input  logic                 ID_use_rs2,
    input  logic [REG_IDX_W-1:0] ID_Wreg,
    input  logic                 ID_wen,
    input  logic                 EX_flush,
    output logic                 stall,
    output logic                 id_ex_bubble,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic                 hazard_err
);

    // Run counter must be able to hold MAX_STALL+1 to detect the overrun.
    localparam int              RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);

    logic                     match_rs1, match_rs2, hazard;
    logic [WB_CTRL_WEN_BIT:0] id_wb_ctrl;
    sb_entry_t                push;
    stall_state_e             state;
    logic [RUN_W-1:0]         run_cnt, run_inc;

    assign hazard       = ID_valid && (match_rs1 || match_rs2);
    assign stall        = hazard && !EX_flush;
    assign id_ex_bubble = hazard || EX_flush;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        id_wb_ctrl                  = '0;
        id_wb_ctrl[WB_CTRL_WEN_BIT] = ID_wen;
        push                        = '0;
        if (!stall && !EX_flush) begin
            push.v = ID_valid && id_wb_ctrl[WB_CTRL_WEN_BIT];
            push.r = ID_Wreg;
        end
    end

    hazard_scoreboard #(
        .WB_BYPASS (WB_BYPASS),
        .R0_ZERO   (R0_ZERO)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .rs1       (ID_rs1),
        .rs2       (ID_rs2),
        .use_rs1   (ID_use_rs1),
        .use_rs2   (ID_use_rs2),
        .match_rs1 (match_rs1),
        .match_rs2 (match_rs2)
    );

    // Run length the counter takes if this cycle stalls.
    always_comb begin
        run_inc = RUN_W'(1);
        if (state == STALL)
            run_inc = (run_cnt == RUN_SAT) ? RUN_SAT : run_cnt + RUN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= RUN;
            run_cnt    <= '0;
            stall_cnt  <= '0;
            hazard_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (stall) begin
                        state   <= STALL;
                        run_cnt <= run_inc;
                    end
                end
                STALL: begin
                    if (stall) begin
                        run_cnt <= run_inc;
                    end else begin
                        state   <= RUN;
                        run_cnt <= '0;
                    end
                end
            endcase
            if (stall && (run_inc > RUN_MAX))
                hazard_err <= 1'b1;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_hazard_stall_unit.sv
module tb_id_hazard_stall_unit;

    localparam int CNT_W     = 16;
    localparam int MAX_STALL = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             ID_valid, ID_use_rs1, ID_use_rs2, ID_wen, EX_flush;
    logic [2:0]       ID_rs1, ID_rs2, ID_Wreg;
    logic             stall_a, bub_a, err_a, stall_b, bub_b, err_b;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // a: WB_BYPASS=0, R0_ZERO=0    b: WB_BYPASS=1, R0_ZERO=1
    id_hazard_stall_unit #(.WB_BYPASS(1'b0), .R0_ZERO(1'b0), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut_a (
        .clk(clk), .reset(reset), .ID_valid(ID_valid), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_Wreg(ID_Wreg), .ID_wen(ID_wen),
        .EX_flush(EX_flush), .stall(stall_a), .id_ex_bubble(bub_a), .stall_cnt(cnt_a),
        .hazard_err(err_a));

    id_hazard_stall_unit #(.WB_BYPASS(1'b1), .R0_ZERO(1'b1), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut_b (
        .clk(clk), .reset(reset), .ID_valid(ID_valid), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_Wreg(ID_Wreg), .ID_wen(ID_wen),
        .EX_flush(EX_flush), .stall(stall_b), .id_ex_bubble(bub_b), .stall_cnt(cnt_b),
        .hazard_err(err_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
                         input int wreg, input logic wen, input logic fl);
        ID_valid   = v;
        ID_rs1     = 3'(rs1);
        ID_rs2     = 3'(rs2);
        ID_use_rs1 = u1;
        ID_use_rs2 = u2;
        ID_Wreg    = 3'(wreg);
        ID_wen     = wen;
        EX_flush   = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       v, u1, u2, wen, fl;
        logic [2:0] rs1, rs2, wreg;
        logic       sa, ba, sb, bb;
    } vec_t;

    function automatic vec_t mk(input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
                                input int wreg, input logic wen, input logic fl,
                                input logic sa, input logic ba, input logic sb, input logic bb);
        vec_t t;
        t.v = v; t.rs1 = 3'(rs1); t.rs2 = 3'(rs2); t.u1 = u1; t.u2 = u2;
        t.wreg = 3'(wreg); t.wen = wen; t.fl = fl;
        t.sa = sa; t.ba = ba; t.sb = sb; t.bb = bb;
        return t;
    endfunction

    // ---------------- reference model ----------------
    // History of what each configuration pushed into the pipe, newest first.
    typedef struct {
        logic       v;
        logic [2:0] r;
    } ent_t;

    ent_t hist_a[$], hist_b[$];
    int   mcnt_a, mcnt_b, mrun_a, mrun_b;
    logic merr_a, merr_b;

    // A producer issued k cycles ago (k=1..3) is still unwritten in a
    // pipeline without forwarding; write-before-read removes the oldest.
    function automatic logic model_hazard(input ent_t h[$], input int depth, input bit r0z,
                                          input logic v, input logic u1, input logic [2:0] rs1,
                                          input logic u2, input logic [2:0] rs2);
        logic hz = 1'b0;
        for (int i = 0; i < depth; i++) begin
            if (h[i].v && u1 && h[i].r == rs1 && !(r0z && rs1 == 0)) hz = 1'b1;
            if (h[i].v && u2 && h[i].r == rs2 && !(r0z && rs2 == 0)) hz = 1'b1;
        end
        return v && hz;
    endfunction

    task automatic model_reset();
        hist_a = {};
        hist_b = {};
        for (int i = 0; i < 3; i++) begin
            hist_a.push_back('{1'b0, 3'd0});
            hist_b.push_back('{1'b0, 3'd0});
        end
        mcnt_a = 0; mcnt_b = 0; mrun_a = 0; mrun_b = 0;
        merr_a = 1'b0; merr_b = 1'b0;
    endtask

    vec_t vecs[23];

    initial begin
        logic hz, es, eb;
        ent_t e;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // ---- reset state ----
        do_reset();
        check("reset_stall_a", stall_a, 0);
        check("reset_bubble_a", bub_a, 0);
        check("reset_cnt_a", cnt_a, 0);
        check("reset_err_a", err_a, 0);

        // ---- directed table: v rs1 rs2 u1 u2 wreg wen fl | sa ba sb bb ----
        vecs[0]  = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0); // I1 writes r2
        vecs[1]  = mk(1, 3, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0); // I2 reads r3,r4
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); // I1 writes r5
        vecs[5]  = mk(1, 5, 0, 1, 0, 6, 0, 0, 1, 1, 1, 1); // distance 1
        vecs[6]  = mk(1, 5, 0, 1, 0, 6, 0, 0, 1, 1, 1, 1);
        vecs[7]  = mk(1, 5, 0, 1, 0, 6, 0, 0, 1, 1, 0, 0);
        vecs[8]  = mk(1, 5, 0, 1, 0, 6, 0, 0, 0, 0, 0, 0); // issues
        vecs[9]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); // I1 writes r5
        vecs[10] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0); // independent
        vecs[11] = mk(1, 5, 0, 1, 0, 6, 0, 0, 1, 1, 1, 1); // distance 2
        vecs[12] = mk(1, 5, 0, 1, 0, 6, 0, 0, 1, 1, 0, 0);
        vecs[13] = mk(1, 5, 0, 1, 0, 6, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); // I1 writes r5
        vecs[15] = mk(1, 5, 0, 1, 0, 7, 1, 1, 0, 1, 0, 1); // hazard + flush
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[17] = mk(1, 7, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0); // squashed r7 absent
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // I1 writes r0
        vecs[19] = mk(1, 0, 0, 1, 0, 3, 0, 0, 1, 1, 0, 0); // reads r0
        vecs[20] = mk(1, 0, 0, 1, 0, 3, 0, 0, 1, 1, 0, 0);
        vecs[21] = mk(1, 0, 0, 1, 0, 3, 0, 0, 1, 1, 0, 0);
        vecs[22] = mk(1, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                  vecs[i].wreg, vecs[i].wen, vecs[i].fl);
            @(negedge clk);
            check($sformatf("tbl%0d_stall_a", i), stall_a, vecs[i].sa);
            check($sformatf("tbl%0d_bubble_a", i), bub_a, vecs[i].ba);
            check($sformatf("tbl%0d_stall_b", i), stall_b, vecs[i].sb);
            check($sformatf("tbl%0d_bubble_b", i), bub_b, vecs[i].bb);
            if (i == 8) begin
                check("dist1_cnt_a", cnt_a, 3);
                check("dist1_cnt_b", cnt_b, 2);
            end
            next_cycle();
        end
        check("table_cnt_a", cnt_a, 8);
        check("table_cnt_b", cnt_b, 3);
        check("table_err_a", err_a, 0);
        check("table_err_b", err_b, 0);

        // ---- reset in the middle of a stall ----
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) next_cycle();
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        next_cycle();
        drive(1, 5, 0, 1, 0, 6, 0, 0);
        @(negedge clk);
        check("midrst_pre_stall_a", stall_a, 1);
        reset = 1'b0;
        next_cycle();
        check("midrst_stall_a", stall_a, 0);
        check("midrst_bubble_a", bub_a, 0);
        check("midrst_cnt_a", cnt_a, 0);
        reset = 1'b1;

        // ---- randomized run against the reference model ----
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1), ($urandom_range(0, 9) == 0));
            @(negedge clk);
            // configuration a
            hz = model_hazard(hist_a, 3, 1'b0, ID_valid, ID_use_rs1, ID_rs1, ID_use_rs2, ID_rs2);
            es = hz && !EX_flush;
            eb = hz || EX_flush;
            check($sformatf("rnd%0d_stall_a", c), stall_a, es);
            check($sformatf("rnd%0d_bubble_a", c), bub_a, eb);
            e.v = (!es && !EX_flush) ? (ID_valid && ID_wen) : 1'b0;
            e.r = ID_Wreg;
            hist_a.push_front(e);
            void'(hist_a.pop_back());
            if (es) begin mcnt_a++; mrun_a = (mrun_a >= MAX_STALL + 1) ? MAX_STALL + 1 : mrun_a + 1; end
            else mrun_a = 0;
            if (mrun_a > MAX_STALL) merr_a = 1'b1;
            // configuration b
            hz = model_hazard(hist_b, 2, 1'b1, ID_valid, ID_use_rs1, ID_rs1, ID_use_rs2, ID_rs2);
            es = hz && !EX_flush;
            eb = hz || EX_flush;
            check($sformatf("rnd%0d_stall_b", c), stall_b, es);
            check($sformatf("rnd%0d_bubble_b", c), bub_b, eb);
            e.v = (!es && !EX_flush) ? (ID_valid && ID_wen) : 1'b0;
            e.r = ID_Wreg;
            hist_b.push_front(e);
            void'(hist_b.pop_back());
            if (es) begin mcnt_b++; mrun_b = (mrun_b >= MAX_STALL + 1) ? MAX_STALL + 1 : mrun_b + 1; end
            else mrun_b = 0;
            if (mrun_b > MAX_STALL) merr_b = 1'b1;
            next_cycle();
        end
        check("rnd_cnt_a", cnt_a, mcnt_a);
        check("rnd_cnt_b", cnt_b, mcnt_b);
        check("rnd_err_a", err_a, merr_a);
        check("rnd_err_b", err_b, merr_b);

        // ---- overlong stall with the scoreboard compare tied off ----
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        drive(1, 5, 0, 1, 0, 6, 0, 0);
        force dut_a.u_sb.match_rs1 = 1'b1;
        @(negedge clk);
        check("tied_stall_a", stall_a, 1);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            check($sformatf("tied_err_after_%0d", k), err_a, (k >= 4) ? 1 : 0);
        end
        release dut_a.u_sb.match_rs1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        check("err_sticky_stall_a", stall_a, 0);
        check("err_sticky_a", err_a, 1);
        check("err_cnt_a", cnt_a, 4);
        do_reset();
        check("err_cleared_a", err_a, 0);
        check("err_cleared_cnt_a", cnt_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
